mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the five-stage MIPS pipeline.
- Accepts MDU ops issued from E, sequences a fixed-latency busy window, and owns the HI/LO registers.
- Generates the D-stage stall when a decoded instruction needs the MDU (the decode stage's mlu_use output) while the unit is busy or starting.
- Sits beside the E-stage ALU; stall feeds the pipeline freeze/bubble logic.

Parameters:
- MUL_LAT, 5: busy cycles for MULT/MULTU; legal range 1..15.
- DIV_LAT, 10: busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous active-high reset
- start  in  1  E-stage instruction is an MDU op this cycle; qualified by the pipeline as a valid, non-bubble instruction
- md_op  in  3  op code from the package: MULT, MULTU, DIV, DIVU, MTHI, MTLO
- E_A  in  32  rs operand, already forwarded
- E_B  in  32  rt operand, already forwarded
- d_mdu_use  in  1  D-stage instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- busy  out  1  operation in flight
- stall  out  1  freeze PC/F/D and insert a bubble into E
- hi  out  32  HI register, read by MFHI in E
- lo  out  32  LO register, read by MFLO in E

Behaviour:
- Single clock clk; reset is synchronous, active-high. While reset is high at a rising edge: state=IDLE, cnt=0, hi=0, lo=0, busy=0. The pending result registers are cleared.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, cnt counts down.
- IDLE with start and MULT/MULTU/DIV/DIVU:
  - Next edge: latch the full 64-bit result into pend_hi/pend_lo and load cnt with MUL_LAT or DIV_LAT.
  - Go to BUSY. busy rises in the cycle after start.
- BUSY: cnt decrements each edge. On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, state=IDLE.
  - Net effect: busy is high for exactly LAT cycles.
  - hi/lo show the new value in the first cycle busy is low.
- MTHI/MTLO with start in IDLE: hi (or lo) <= E_A at the next edge; no busy window.
- start while BUSY: ignored, no state change. Pipeline stall makes this unreachable; the bench checks it as an assertion.
- stall = d_mdu_use && (busy || (start && md_op is MULT/MULTU/DIV/DIVU)).
  - Combinational.
  - MTHI/MTLO in E never cause a stall.
- Arithmetic:
  - MULT: signed 32x32->64; MULTU: unsigned. hi=upper 32 bits, lo=lower 32 bits.
  - DIV: signed, quotient truncated toward zero into lo; remainder into hi, carrying the sign of the dividend.
  - DIVU: unsigned.
  - Divisor==0: busy window still runs; hi/lo unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Reset mid-operation: the operation is discarded, busy=0 in the next cycle, and hi/lo are zeroed.

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit), placed after d_mdu_use. It is asserted on exception/eret flush.
  - cancel high in BUSY: go to IDLE next edge; hi/lo keep their old value; pending result dropped.
  - cancel high together with start: start is suppressed, including MTHI/MTLO.
  - cancel has priority below reset.
- Undefined: no cancel port; every accepted op completes.

Decomposition:
- Package mdu_pkg holds:
  - md_op encodings: MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, NONE=0.
  - State encoding: IDLE, BUSY.
  - Default latency constants.
- Sub-module mdu_arith: purely combinational 64-bit product/quotient-remainder from md_op, E_A, E_B, including the divide-by-zero valid flag.
- mdu_ctrl keeps the FSM, counter, pending registers, HI/LO and the stall equation.

Test Plan:
- MULT E_A=0xFFFFFFFE (-2), E_B=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU E_A=0xFFFFFFFF, E_B=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV E_A=-7, E_B=2 -> busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with E_B=0 and prior hi=0x11, lo=0x22 -> busy 10 cycles, hi=0x11, lo=0x22.
- Start DIV with d_mdu_use=1 held throughout -> stall=1 in the start cycle and all 10 busy cycles, then 0 on the cycle hi/lo update. Same sequence with d_mdu_use=0 -> stall=0 throughout.
- MTLO E_A=0xDEADBEEF in IDLE -> lo=0xDEADBEEF next cycle, busy never rises, stall=0 even with d_mdu_use=1.
- Reset asserted in cycle 3 of a MULT -> next cycle busy=0, hi=lo=0, and no late write occurs. With MDU_CANCEL_EN, cancel in cycle 3 -> busy=0 next cycle and hi/lo keep their prior values.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU controller: op encodings, FSM states and default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

  // Ops that open a busy window (everything except the HI/LO moves).
  function automatic logic is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply / divide datapath; valid drops for a divide by zero.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        valid
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        dvs_nz;
  logic signed [32:0] dvd_x;
  logic signed [32:0] dvs_x;
  logic [31:0]        quo_s;
  logic [31:0]        rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  always_comb begin
    // A zero divisor is replaced by one so the dividers never see x/0; the result is discarded anyway.
    dvs_nz = (b == 32'd0) ? 32'd1 : b;
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    // 33-bit signed divide keeps 0x80000000 / -1 from overflowing; low half gives 0x80000000.
    dvd_x  = $signed({a[31], a});
    dvs_x  = $signed({dvs_nz[31], dvs_nz});
    quo_s  = 32'(dvd_x / dvs_x);
    rem_s  = 32'(dvd_x % dvs_x);
    quo_u  = a / dvs_nz;
    rem_u  = a % dvs_nz;

    result = '0;
    valid  = 1'b1;
    case (md_op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        result = {rem_s, quo_s};
        valid  = (b != 32'd0);
      end
      MD_DIVU: begin
        result = {rem_u, quo_u};
        valid  = (b != 32'd0);
      end
      default: begin
        result = '0;
        valid  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: busy-window FSM, HI/LO ownership and D-stage stall generation.
// Optional flush input enabled by defining MDU_CANCEL_EN.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        d_mdu_use,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  state_e      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_valid;
  logic [63:0] arith_res;
  logic        arith_valid;
  logic        kill;

`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  mdu_arith u_arith (
    .md_op  (md_op),
    .a      (E_A),
    .b      (E_B),
    .result (arith_res),
    .valid  (arith_valid)
  );

  // start is a one-cycle issue strobe from E; stall holds D (and bubbles E) so a new MDU
  // op is never issued while the unit is busy or in the cycle its window is opening.
  assign stall = d_mdu_use && (busy || (start && is_arith(md_op)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      busy       <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !kill) begin
            case (md_op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                pend_hi    <= arith_res[63:32];
                pend_lo    <= arith_res[31:0];
                pend_valid <= arith_valid;
                cnt        <= is_div(md_op) ? DIV_CNT : MUL_CNT;
                state      <= ST_BUSY;
                busy       <= 1'b1;
              end
              MD_MTHI: hi <= E_A;
              MD_MTLO: lo <= E_A;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (kill) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            cnt        <= 4'd0;
            pend_valid <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              if (pend_valid) begin
                hi <= pend_hi;
                lo <= pend_lo;
              end
              pend_valid <= 1'b0;
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
